// File: rtl/apb_mem_bridge.sv
// APB slave to byte-wide memory bridge: one word per APB transfer, one byte per cycle.
// Optional alignment check with pslverr_o: define MEM_BRIDGE_ALIGN_CHECK_EN.
module apb_mem_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE       = 8,
  localparam int BPW       = DATA_WIDTH / BYTE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  input  logic [BPW-1:0]        pstrb_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [BYTE-1:0]       mem_data_o,
  output logic                  mem_pwrite_o,
  input  logic [BYTE-1:0]       mem_data_i
);

  localparam int KW = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [BPW-1:0]        strb_q;
  logic                  write_q;
  logic                  err_q;
  logic [KW-1:0]         k_q;
  logic                  setup;
  logic                  last;
  logic                  misalign;

  assign setup = psel_i && !penable_i;
  assign last  = (k_q == KW'(BPW - 1));

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
  assign misalign = |paddr_i[KW-1:0];
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (setup) begin
            base_q  <= paddr_i;
            wdata_q <= pwdata_i;
            strb_q  <= pstrb_i;
            write_q <= pwrite_i;
            err_q   <= misalign;
            k_q     <= '0;
          end
        end
        XFER: begin
          if (!write_q)
            rdata_q[k_q*BYTE +: BYTE] <= mem_data_i;
          k_q <= last ? '0 : k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup) state_d = misalign ? DONE : XFER;
      XFER:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write enable is gated by reset so an aborted transfer stops cleanly.
  always_comb begin
    mem_addr_o   = base_q;
    mem_data_o   = '0;
    mem_pwrite_o = 1'b0;
    prdata_o     = '0;
    pready_o     = 1'b0;
    pslverr_o    = 1'b0;
    unique case (state_q)
      XFER: begin
        mem_addr_o = base_q + ADDR_WIDTH'(k_q);
        if (write_q) begin
          mem_data_o   = wdata_q[k_q*BYTE +: BYTE];
          mem_pwrite_o = strb_q[k_q] && !rst_i;
        end
      end
      DONE: begin
        pready_o = 1'b1;
        if (!write_q && !err_q)
          prdata_o = rdata_q;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        pslverr_o = err_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Directed bench for apb_mem_bridge with a 256-byte memory model
// and a log of every memory write pulse.
module tb_apb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic        mem_pwrite_o;
  logic [7:0]  mem_data_i;

  always #5 clk = ~clk;

  apb_mem_bridge dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .pstrb_i     (pstrb),
    .prdata_o    (prdata_o),
    .pready_o    (pready_o),
    .pslverr_o   (pslverr_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_pwrite_o(mem_pwrite_o),
    .mem_data_i  (mem_data_i)
  );

  logic [7:0]  mem [256];
  logic        pl_en;
  logic [7:0]  pl_a;
  logic [7:0]  pl_d;
  int          wcnt;
  logic [31:0] wlog_a [64];
  logic [7:0]  wlog_d [64];

  assign mem_data_i = mem[mem_addr_o[7:0]];

  always @(posedge clk) begin
    if (pl_en)
      mem[pl_a] <= pl_d;
    if (mem_pwrite_o) begin
      mem[mem_addr_o[7:0]] <= mem_data_o;
      wlog_a[wcnt[5:0]]    <= mem_addr_o;
      wlog_d[wcnt[5:0]]    <= mem_data_o;
      wcnt                 <= wcnt + 1;
    end
  end

  int checks;
  int failures;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Setup in the current cycle; returns cycles-to-pready, read data, error.
  task automatic xfer(input  logic        wr,
                      input  logic [31:0] a,
                      input  logic [31:0] d,
                      input  logic [3:0]  s,
                      input  int          drop_at,
                      output logic [31:0] rd,
                      output logic        err,
                      output int          lat);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    lat     = -1;
    rd      = '0;
    err     = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (drop_at > 0 && c >= drop_at) begin
        psel    = 1'b0;
        penable = 1'b0;
      end else begin
        penable = 1'b1;
      end
      if (pready_o) begin
        lat = c;
        rd  = prdata_o;
        err = pslverr_o;
      end else begin
        chk("prdata_wait", prdata_o, 32'h0);
      end
    end
    @(posedge clk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwr;
  } vec_t;

  vec_t        vt [8];
  logic [31:0] rd;
  logic        err;
  int          lat;
  int          w0;
  int          wwrap;

  initial begin
    vt[0] = '{1'b1, 32'h10, 32'hDDCCBBAA, 4'hF, 32'h0, 1'b0, 5, 4};
    vt[1] = '{1'b0, 32'h10, 32'h0, 4'h0, 32'hDDCCBBAA, 1'b0, 5, 0};
    vt[2] = '{1'b1, 32'h20, 32'h44332211, 4'h5, 32'h0, 1'b0, 5, 2};
    vt[3] = '{1'b0, 32'h20, 32'h0, 4'h0, 32'hFF33FF11, 1'b0, 5, 0};
    vt[4] = '{1'b1, 32'h30, 32'h12345678, 4'h0, 32'h0, 1'b0, 5, 0};
    vt[5] = '{1'b0, 32'h30, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, 5, 0};
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    vt[6] = '{1'b1, 32'hFFFFFFFE, 32'h04030201, 4'hF, 32'h0, 1'b1, 1, 0};
    vt[7] = '{1'b0, 32'hFFFFFFFE, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0};
`else
    vt[6] = '{1'b1, 32'hFFFFFFFE, 32'h04030201, 4'hF, 32'h0, 1'b0, 5, 4};
    vt[7] = '{1'b0, 32'hFFFFFFFE, 32'h0, 4'h0, 32'h04030201, 1'b0, 5, 0};
`endif

    checks   = 0;
    failures = 0;
    wwrap    = 0;
    rst      = 1'b1;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    pstrb    = '0;
    pl_en    = 1'b0;
    pl_a     = '0;
    pl_d     = '0;
    idle(2);
    rst = 1'b0;

    chk("rst_prdata", prdata_o, 32'h0);
    chk("rst_pready", {31'h0, pready_o}, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr_o}, 32'h0);
    chk("rst_mem_pwrite", {31'h0, mem_pwrite_o}, 32'h0);
    chk("rst_mem_data", {24'h0, mem_data_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);

    for (int i = 0; i < 4; i++) begin
      preload(8'h20 + 8'(i), 8'hFF);
      preload(8'h30 + 8'(i), 8'h5A);
      preload(8'h50 + 8'(i), 8'hEE);
    end

    for (int i = 0; i < 8; i++) begin
      w0 = wcnt;
      if (i == 6) wwrap = wcnt;
      xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, 0,
           rd, err, lat);
      chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_prdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_pslverr", i), {31'h0, err},
          {31'h0, vt[i].exp_err});
      chk($sformatf("v%0d_nwrites", i), wcnt - w0, vt[i].exp_nwr);
      chk($sformatf("v%0d_prdata_after", i), prdata_o, 32'h0);
      idle(1);
    end

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w10_addr%0d", i), wlog_a[i], 32'h10 + i);
      chk($sformatf("w10_data%0d", i), {24'h0, wlog_d[i]},
          32'hAA + 32'h11 * i);
    end
    chk("m20", {24'h0, mem[8'h20]}, 32'h11);
    chk("m21", {24'h0, mem[8'h21]}, 32'hFF);
    chk("m22", {24'h0, mem[8'h22]}, 32'h33);
    chk("m23", {24'h0, mem[8'h23]}, 32'hFF);
`ifndef MEM_BRIDGE_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_addr%0d", i), wlog_a[wwrap + i],
          32'hFFFFFFFE + i);
      chk($sformatf("wrap_data%0d", i), {24'h0, wlog_d[wwrap + i]},
          32'h01 + i);
    end
`endif

    // Reset in the second XFER cycle of a write.
    w0      = wcnt;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h50;
    pwdata  = 32'h0D0C0B0A;
    pstrb   = 4'hF;
    idle(1);
    penable = 1'b1;
    idle(1);
    rst = 1'b1;
    #1;
    chk("rstx_addr_k1", mem_addr_o, 32'h51);
    chk("rstx_pwrite_gated", {31'h0, mem_pwrite_o}, 32'h0);
    idle(1);
    rst     = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    chk("rstx_prdata", prdata_o, 32'h0);
    chk("rstx_pready", {31'h0, pready_o}, 32'h0);
    chk("rstx_pslverr", {31'h0, pslverr_o}, 32'h0);
    chk("rstx_mem_pwrite", {31'h0, mem_pwrite_o}, 32'h0);
    chk("rstx_mem_data", {24'h0, mem_data_o}, 32'h0);
    chk("rstx_mem_addr", mem_addr_o, 32'h0);
    chk("rstx_nwrites", wcnt - w0, 1);
    chk("rstx_m50", {24'h0, mem[8'h50]}, 32'h0A);
    chk("rstx_m51", {24'h0, mem[8'h51]}, 32'hEE);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk($sformatf("rstx_idle_pready%0d", i), {31'h0, pready_o}, 32'h0);
      chk($sformatf("rstx_idle_addr%0d", i), mem_addr_o, 32'h0);
    end

    // Back-to-back write then read, psel dropped mid-write.
    w0 = wcnt;
    xfer(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 2, rd, err, lat);
    chk("b2b_wr_latency", lat, 5);
    chk("b2b_wr_nwrites", wcnt - w0, 4);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, err, lat);
    chk("b2b_rd_latency", lat, 5);
    chk("b2b_rd_prdata", rd, 32'hCAFEF00D);
    chk("b2b_rd_after", prdata_o, 32'h0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
